btn_start_pulse_gen: RTL and testbench
======================================

Name: btn_start_pulse_gen

Overview:
Upstream front end for the 3-second LED indicator and other one-shot consumers in the BlackJack datapath. It takes a raw, bouncing push-button input, synchronises and debounces it, and emits exactly one single-cycle start_pulse per confirmed press. A lock input suppresses pulses while a downstream consumer is busy. A debounced level and a press counter are also exported for game-control logic.

Parameters:
DB_CYCLES, 2_000_000, stable-sample count needed to confirm a press or a release (20 ms at 100 MHz); minimum 2
CNT_W, 32, width of the debounce/repeat counters; must hold max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
REPEAT_DELAY, 50_000_000, cycles held before the first auto-repeat pulse (BTN_REPEAT_EN only)
REPEAT_PERIOD, 20_000_000, cycles between subsequent auto-repeat pulses (BTN_REPEAT_EN only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn_in  input  1  raw asynchronous button, active-high
lock  input  1  1 = suppress start_pulse (e.g. tied to downstream busy/LED_3s)
start_pulse  output  1  single-cycle pulse per accepted press
btn_level  output  1  debounced button level
press_cnt  output  8  count of emitted start_pulses, wraps

Behaviour:
- Reset (rst=0, asynchronous): sync flops=0, state=IDLE, counters=0, start_pulse=0, btn_level=0, press_cnt=0.
- Two-flop synchroniser on btn_in; FSM sees only the second flop (s).
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. Debounce counter db_cnt.
- IDLE: s=1 -> PRESS_DB, db_cnt=1.
- PRESS_DB: s=0 -> IDLE, db_cnt=0 (bounce rejected, no pulse). s=1 and db_cnt==DB_CYCLES-1 -> HELD, db_cnt=0. Otherwise db_cnt+1.
- HELD: s=0 -> RELEASE_DB, db_cnt=1.
- RELEASE_DB: s=1 -> HELD, db_cnt=0, no new pulse. s=0 and db_cnt==DB_CYCLES-1 -> IDLE, db_cnt=0. Otherwise db_cnt+1.
- start_pulse is registered. It is 1 for exactly the one cycle on which the state register becomes HELD from PRESS_DB, if lock=0 on that cycle. If lock=1, the press is consumed silently: the FSM still enters HELD and no pulse is deferred.
- Latency: count the first edge sampling btn_in=1 as edge 1. With btn_in held stable, start_pulse is high after edge DB_CYCLES+2.
- btn_level=1 while in HELD or RELEASE_DB, else 0. It updates on the same edge as the state.
- press_cnt increments by 1 on each cycle start_pulse=1. Wraps 255->0.
- The pulse never exceeds one cycle. A press held indefinitely produces one pulse (without BTN_REPEAT_EN).
- Reset mid-press: all state is cleared immediately. After reset is released, a still-held button is treated as a new press and requires full debounce.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - A repeat counter rp_cnt runs while in HELD.
  - An extra start_pulse fires after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles.
  - Each repeat pulse is subject to lock (suppressed, not deferred) and increments press_cnt when emitted.
  - rp_cnt clears on any exit from HELD, including a bounce into RELEASE_DB.
- Undefined:
  - No repeat counter is built. One pulse per press only.
  - The REPEAT_* parameters are ignored.

Test Plan:
- DB_CYCLES=4; btn_in 0->1 held 20 cycles, then released -> start_pulse high for exactly 1 cycle after edge 6. press_cnt=1. btn_level=1 from edge 6 until 4 stable-low samples after release.
- DB_CYCLES=4; btn_in toggles 1,1,0,1,1,0 (bounce shorter than 4) -> no start_pulse, press_cnt=0, state returns to IDLE.
- DB_CYCLES=4; press held with lock=1 across the confirm edge, then lock=0 while still held -> no pulse at any time. press_cnt=0. btn_level=1.
- DB_CYCLES=4; in HELD, inject a 2-cycle low glitch -> FSM goes to RELEASE_DB and back to HELD. No second pulse. btn_level stays 1.
- Pulse 256 accepted presses -> press_cnt wraps to 0. Assert rst=0 mid-PRESS_DB -> all outputs 0 asynchronously. After release of rst with btn_in held, the next pulse comes DB_CYCLES+2 edges later.
- BTN_REPEAT_EN with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5; hold 30 cycles past confirm -> pulses at confirm, +10, +15, +20, +25, +30. press_cnt=6.

Source files
------------

// File: rtl/btn_start_pulse_gen.sv
// btn_start_pulse_gen: synchronise and debounce a push-button, emit one start pulse per confirmed press
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   btn_in      raw asynchronous button, active-high
//   lock        1 suppresses start_pulse; a suppressed press is dropped, not deferred
//   start_pulse registered single-cycle pulse per accepted press
//   btn_level   debounced button level (HELD or RELEASE_DB)
//   press_cnt   count of emitted start_pulses, wraps at 256
//
// Optional feature: define BTN_REPEAT_EN for auto-repeat pulses while held.
module btn_start_pulse_gen #(
    parameter int DB_CYCLES     = 2_000_000,
    parameter int CNT_W         = 32,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       lock,
    output logic       start_pulse,
    output logic       btn_level,
    output logic [7:0] press_cnt
);
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] db_q, db_d;
    logic             sync1_q, s_q;
    logic             pulse_q, pulse_d;
    logic [7:0]       cnt_q;
    logic             confirm;
    logic             fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            state_q <= IDLE;
            db_q    <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            s_q     <= sync1_q;
            state_q <= state_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_q + {7'd0, pulse_d};
        end
    end

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        confirm = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_q) begin
                    state_d = PRESS_DB;
                    db_d    = ONE;
                end
            end
            PRESS_DB: begin
                if (!s_q) begin
                    state_d = IDLE;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = HELD;
                    db_d    = '0;
                    confirm = 1'b1;
                end else begin
                    db_d = db_q + ONE;
                end
            end
            HELD: begin
                if (!s_q) begin
                    state_d = RELEASE_DB;
                    db_d    = ONE;
                end
            end
            RELEASE_DB: begin
                if (s_q) begin
                    state_d = HELD;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = IDLE;
                    db_d    = '0;
                end else begin
                    db_d = db_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                db_d    = '0;
            end
        endcase
    end

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] RP_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rp_q, rp_d;
    logic             rep_q, rep_d;
    logic             rp_fire;

    // rp_q counts cycles spent staying in HELD; any exit (or bounce) clears it
    always_comb begin
        rp_fire = 1'b0;
        rp_d    = '0;
        rep_d   = 1'b0;
        if (state_q == HELD && s_q) begin
            rp_fire = rp_q == (rep_q ? RP_NEXT : RP_FIRST);
            rp_d    = rp_fire ? '0 : rp_q + ONE;
            rep_d   = rep_q | rp_fire;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp_q  <= '0;
            rep_q <= 1'b0;
        end else begin
            rp_q  <= rp_d;
            rep_q <= rep_d;
        end
    end

    assign fire = confirm | rp_fire;
`else
    logic unused_rp;
    assign unused_rp = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
    assign fire      = confirm;
`endif

    // lock drops the request outright; nothing is remembered for later
    assign pulse_d     = fire & ~lock;
    assign start_pulse = pulse_q;
    assign btn_level   = state_q == HELD || state_q == RELEASE_DB;
    assign press_cnt   = cnt_q;
endmodule

// File: tb/tb_btn_start_pulse_gen.sv
// tb_btn_start_pulse_gen: self-checking bench for btn_start_pulse_gen (default build)
module tb_btn_start_pulse_gen;
    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       lock;
    logic       start_pulse;
    logic       btn_level;
    logic [7:0] press_cnt;

    int checks;
    int failures;

    btn_start_pulse_gen #(
        .DB_CYCLES    (DB),
        .CNT_W        (8),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .lock       (lock),
        .start_pulse(start_pulse),
        .btn_level  (btn_level),
        .press_cnt  (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: the button as seen two edges late, filtered by a run-length rule
    logic       m_q[$];
    logic       m_level;
    int         m_run;
    logic       m_pulse;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_q     = '{1'b0, 1'b0};
        m_level = 1'b0;
        m_run   = 0;
        m_pulse = 1'b0;
        m_cnt   = 8'd0;
    endtask

    task automatic model_edge(input logic b, input logic l);
        logic s;
        s = m_q[0];
        void'(m_q.pop_front());
        m_q.push_back(b);
        m_pulse = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == DB) begin
                m_level = s;
                m_run   = 0;
                m_pulse = s & ~l;
            end
        end else begin
            m_run = 0;
        end
        m_cnt = m_cnt + 8'(m_pulse);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".pulse"}, 32'(start_pulse), 32'(m_pulse));
        chk({tag, ".level"}, 32'(btn_level), 32'(m_level));
        chk({tag, ".cnt"}, 32'(press_cnt), 32'(m_cnt));
    endtask

    // called and returns at a falling edge; outputs are sampled there
    task automatic step(input logic b, input logic l);
        btn_in = b;
        lock   = l;
        @(posedge clk);
        model_edge(b, l);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        btn_in = 1'b0;
        lock   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press(input string tag);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            model_check(tag);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            model_check(tag);
        end
    endtask

    typedef struct {
        logic       b;
        logic       l;
        logic       p;
        logic       v;
        logic [7:0] c;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] saved;
    logic       rb;
    int         n;

    initial begin
        checks   = 0;
        failures = 0;
        // edge i+1 samples btn; confirm on edge 6, release confirmed on edge 14
        for (int i = 0; i < 16; i++) begin
            tbl[i].b = i < 8;
            tbl[i].l = 1'b0;
            tbl[i].p = i == 5;
            tbl[i].v = i >= 5 && i <= 12;
            tbl[i].c = (i >= 5) ? 8'd1 : 8'd0;
        end

        rst    = 1'b0;
        btn_in = 1'b0;
        lock   = 1'b0;
        model_reset();
        #1;
        chk("rst.pulse", 32'(start_pulse), 0);
        chk("rst.level", 32'(btn_level), 0);
        chk("rst.cnt", 32'(press_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].b, tbl[i].l);
            chk($sformatf("tbl%0d.pulse", i), 32'(start_pulse), 32'(tbl[i].p));
            chk($sformatf("tbl%0d.level", i), 32'(btn_level), 32'(tbl[i].v));
            chk($sformatf("tbl%0d.cnt", i), 32'(press_cnt), 32'(tbl[i].c));
        end

        saved = m_cnt;
        for (int i = 0; i < 12; i++) begin
            step((i < 6) ? (i != 2 && i != 5) : 1'b0, 1'b0);
            chk("bounce.pulse", 32'(start_pulse), 0);
            chk("bounce.level", 32'(btn_level), 0);
        end
        chk("bounce.cnt", 32'(press_cnt), 32'(saved));

        for (int i = 0; i < 14; i++) begin
            step(1'b1, i < 8);
            chk("lock.pulse", 32'(start_pulse), 0);
        end
        chk("lock.level", 32'(btn_level), 1);
        chk("lock.cnt", 32'(press_cnt), 32'(saved));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            model_check("lock_rel");
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            model_check("glitch_press");
        end
        saved = press_cnt;
        for (int i = 0; i < 10; i++) begin
            step(i >= 2, 1'b0);
            chk("glitch.pulse", 32'(start_pulse), 0);
            chk("glitch.level", 32'(btn_level), 1);
        end
        chk("glitch.cnt", 32'(press_cnt), 32'(saved));
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            model_check("glitch_rel");
        end

        do_reset();
        for (int k = 0; k < 255; k++) press("wrap");
        chk("wrap.cnt255", 32'(press_cnt), 255);
        press("wrap");
        chk("wrap.cnt0", 32'(press_cnt), 0);

        press("pre_rst");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            model_check("mid");
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.pulse", 32'(start_pulse), 0);
        chk("async_rst.level", 32'(btn_level), 0);
        chk("async_rst.cnt", 32'(press_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= DB + 2; i++) begin
            step(1'b1, 1'b0);
            chk($sformatf("after_rst.edge%0d", i), 32'(start_pulse), 32'(i == DB + 2));
            model_check("after_rst");
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            model_check("after_rst_rel");
        end

        for (int k = 0; k < 120; k++) begin
            rb = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 9);
            for (int j = 0; j < n; j++) begin
                step(rb, $urandom_range(0, 5) == 0);
                model_check("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
